// File: rtl/dds_cmd_pkg.sv
// Shared constants and types for the DDS command sequencer.
// DDS_CMD_REPLY_EN adds the REPLY state used for UART status bytes.
package dds_cmd_pkg;

  localparam int FTW_W = 32;
  localparam int PHW_W = 16;
  localparam int AMP_W = 12;
  localparam int TO_W  = 16;

  localparam logic [7:0] CMD_FTW    = 8'h01;
  localparam logic [7:0] CMD_PHASE  = 8'h02;
  localparam logic [7:0] CMD_AMP    = 8'h03;
  localparam logic [7:0] CMD_WAVE   = 8'h04;
  localparam logic [7:0] CMD_LED    = 8'h08;
  localparam logic [7:0] CMD_COMMIT = 8'h10;
  localparam logic [7:0] CMD_CLR    = 8'h7F;

  localparam logic [7:0] RPL_OK      = 8'hA5;
  localparam logic [7:0] RPL_BADCMD  = 8'hE1;
  localparam logic [7:0] RPL_TIMEOUT = 8'hE2;

  typedef enum logic [1:0] {
    WAVE_SINE     = 2'd0,
    WAVE_SQUARE   = 2'd1,
    WAVE_TRIANGLE = 2'd2,
    WAVE_SAW      = 2'd3
  } wave_t;

`ifdef DDS_CMD_REPLY_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_XFER   = 2'd2,
    ST_REPLY  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_XFER   = 2'd2
  } state_t;
`endif

  function automatic logic cmd_is_known(input logic [7:0] cmd);
    return (cmd == CMD_FTW)  || (cmd == CMD_PHASE)  || (cmd == CMD_AMP) ||
           (cmd == CMD_WAVE) || (cmd == CMD_LED)    || (cmd == CMD_COMMIT) ||
           (cmd == CMD_CLR);
  endfunction

endpackage

// File: rtl/dds_cmd_ctrl_if.sv
// Packet, DDS configuration and status bundle of the command sequencer.
// DDS_CMD_REPLY_EN adds the tx_req/tx_data/tx_busy reply channel.
interface dds_cmd_ctrl_if;

  logic                            recv_done;
  logic [7:0]                      dataA;
  logic [15:0]                     dataB;
  logic [15:0]                     dataC;
  logic [7:0]                      dataD;
  logic                            cfg_valid;
  logic                            cfg_ready;
  logic [dds_cmd_pkg::FTW_W-1:0]   cfg_ftw;
  logic [dds_cmd_pkg::PHW_W-1:0]   cfg_phase;
  logic [dds_cmd_pkg::AMP_W-1:0]   cfg_amp;
  logic [1:0]                      cfg_wave;
  logic                            dds_en;
  logic                            led_en;
  logic                            busy;
  logic                            err;
  logic [7:0]                      drop_cnt;
`ifdef DDS_CMD_REPLY_EN
  logic                            tx_req;
  logic [7:0]                      tx_data;
  logic                            tx_busy;

  modport master (
    input  recv_done, dataA, dataB, dataC, dataD, cfg_ready, tx_busy,
    output cfg_valid, cfg_ftw, cfg_phase, cfg_amp, cfg_wave, dds_en,
           led_en, busy, err, drop_cnt, tx_req, tx_data
  );

  modport slave (
    output recv_done, dataA, dataB, dataC, dataD, cfg_ready, tx_busy,
    input  cfg_valid, cfg_ftw, cfg_phase, cfg_amp, cfg_wave, dds_en,
           led_en, busy, err, drop_cnt, tx_req, tx_data
  );
`else
  modport master (
    input  recv_done, dataA, dataB, dataC, dataD, cfg_ready,
    output cfg_valid, cfg_ftw, cfg_phase, cfg_amp, cfg_wave, dds_en,
           led_en, busy, err, drop_cnt
  );

  modport slave (
    output recv_done, dataA, dataB, dataC, dataD, cfg_ready,
    input  cfg_valid, cfg_ftw, cfg_phase, cfg_amp, cfg_wave, dds_en,
           led_en, busy, err, drop_cnt
  );
`endif

endinterface

// File: rtl/dds_cmd_timeout.sv
// Wait-cycle counter: load clears, en counts, o_expire flags the TO_CYC-th enabled cycle.
module dds_cmd_timeout
  import dds_cmd_pkg::*;
#(
  parameter int TO_CYC = 65535
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_en,
  output logic o_expire
);

  localparam logic [TO_W-1:0] LAST = TO_W'(TO_CYC - 1);

  logic [TO_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + TO_W'(1);
    end
  end

  assign o_expire = i_en && (r_cnt == LAST);

endmodule

// File: rtl/dds_cmd_ctrl.sv
// Decodes UART packets into shadow DDS settings and commits them via valid/ready.
// DDS_CMD_REPLY_EN enables the REPLY state and status byte transmission.
module dds_cmd_ctrl
  import dds_cmd_pkg::*;
#(
  parameter int TO_CYC = 65535
) (
  input  logic           sys_clk,
  input  logic           sys_rst,
  dds_cmd_ctrl_if.master bus
);

  state_t             r_state;
  state_t             w_next_state;
  logic               w_accept;
  logic               w_drop;
  logic               w_xfer_ok;
  logic               w_xfer_to;
  logic               w_to_load;
  logic               w_to_en;
  logic               w_to_expire;

  logic [7:0]         r_cmd;
  logic [15:0]        r_dataB;
  logic [15:0]        r_dataC;
  logic [1:0]         r_dataD;

  logic [FTW_W-1:0]   r_sh_ftw;
  logic [PHW_W-1:0]   r_sh_phase;
  logic [AMP_W-1:0]   r_sh_amp;
  wave_t              r_sh_wave;

  logic [FTW_W-1:0]   r_cfg_ftw;
  logic [PHW_W-1:0]   r_cfg_phase;
  logic [AMP_W-1:0]   r_cfg_amp;
  wave_t              r_cfg_wave;
  logic               r_dds_en;
  logic               r_led_en;
  logic               r_err;
  logic [7:0]         r_drop_cnt;

  // Only the two low aux bits carry meaning in any command.
  logic               w_unused_dataD;
  assign w_unused_dataD = ^bus.dataD[7:2];

`ifdef DDS_CMD_REPLY_EN
  logic [7:0]         r_tx_data;
  logic               r_seen_busy;
  assign w_to_en = (r_state == ST_XFER) || (r_state == ST_REPLY);
`else
  assign w_to_en = (r_state == ST_XFER);
`endif

  dds_cmd_timeout #(
    .TO_CYC   (TO_CYC)
  ) u_timeout (
    .i_clk    (sys_clk),
    .i_rst    (sys_rst),
    .i_load   (w_to_load),
    .i_en     (w_to_en),
    .o_expire (w_to_expire)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_drop       = 1'b0;
    w_xfer_ok    = 1'b0;
    w_xfer_to    = 1'b0;
    w_to_load    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_accept = bus.recv_done;
        if (bus.recv_done) begin
          w_next_state = ST_DECODE;
        end
      end
      ST_DECODE: begin
        w_drop    = bus.recv_done;
        w_to_load = 1'b1;
        if (r_cmd == CMD_COMMIT) begin
          w_next_state = ST_XFER;
        end else begin
`ifdef DDS_CMD_REPLY_EN
          w_next_state = ST_REPLY;
`else
          w_next_state = ST_IDLE;
`endif
        end
      end
      ST_XFER: begin
        w_drop    = bus.recv_done;
        w_xfer_ok = bus.cfg_ready;
        w_xfer_to = !bus.cfg_ready && w_to_expire;
        if (w_xfer_ok || w_xfer_to) begin
          w_to_load = 1'b1;
`ifdef DDS_CMD_REPLY_EN
          w_next_state = ST_REPLY;
`else
          w_next_state = ST_IDLE;
`endif
        end
      end
`ifdef DDS_CMD_REPLY_EN
      ST_REPLY: begin
        w_drop = bus.recv_done;
        // A transmitter that never responds must not wedge the sequencer.
        if ((r_seen_busy && !bus.tx_busy) || w_to_expire) begin
          w_next_state = ST_IDLE;
        end
      end
`endif
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_cmd       <= '0;
      r_dataB     <= '0;
      r_dataC     <= '0;
      r_dataD     <= '0;
      r_sh_ftw    <= '0;
      r_sh_phase  <= '0;
      r_sh_amp    <= '0;
      r_sh_wave   <= WAVE_SINE;
      r_cfg_ftw   <= '0;
      r_cfg_phase <= '0;
      r_cfg_amp   <= '0;
      r_cfg_wave  <= WAVE_SINE;
      r_dds_en    <= 1'b0;
      r_led_en    <= 1'b0;
      r_err       <= 1'b0;
      r_drop_cnt  <= '0;
    end else begin
      if (w_accept) begin
        r_cmd   <= bus.dataA;
        r_dataB <= bus.dataB;
        r_dataC <= bus.dataC;
        r_dataD <= bus.dataD[1:0];
      end
      if (w_drop && (r_drop_cnt != 8'hFF)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
      // Placed after the drop counter so a CLR wins over a same-cycle drop.
      if (r_state == ST_DECODE) begin
        case (r_cmd)
          CMD_FTW:   r_sh_ftw   <= {r_dataB, r_dataC};
          CMD_PHASE: r_sh_phase <= r_dataB;
          CMD_AMP:   r_sh_amp   <= r_dataC[AMP_W-1:0];
          CMD_WAVE:  r_sh_wave  <= wave_t'(r_dataD);
          CMD_LED:   r_led_en   <= r_dataD[0];
          CMD_COMMIT: begin
            r_cfg_ftw   <= r_sh_ftw;
            r_cfg_phase <= r_sh_phase;
            r_cfg_amp   <= r_sh_amp;
            r_cfg_wave  <= r_sh_wave;
            r_dds_en    <= r_dataD[0];
          end
          CMD_CLR: begin
            r_err      <= 1'b0;
            r_drop_cnt <= '0;
          end
          default:   r_err      <= 1'b1;
        endcase
      end
      if (w_xfer_to) begin
        r_err    <= 1'b1;
        r_dds_en <= 1'b0;
      end
    end
  end

`ifdef DDS_CMD_REPLY_EN
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_tx_data   <= '0;
      r_seen_busy <= 1'b0;
    end else begin
      if ((r_state == ST_DECODE) && (r_cmd != CMD_COMMIT)) begin
        r_tx_data <= cmd_is_known(r_cmd) ? RPL_OK : RPL_BADCMD;
      end
      if (w_xfer_ok) begin
        r_tx_data <= RPL_OK;
      end
      if (w_xfer_to) begin
        r_tx_data <= RPL_TIMEOUT;
      end
      if (w_to_load) begin
        r_seen_busy <= 1'b0;
      end else if ((r_state == ST_REPLY) && bus.tx_busy) begin
        r_seen_busy <= 1'b1;
      end
    end
  end

  assign bus.tx_req  = (r_state == ST_REPLY);
  assign bus.tx_data = r_tx_data;
`endif

  assign bus.cfg_valid = (r_state == ST_XFER);
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.cfg_ftw   = r_cfg_ftw;
  assign bus.cfg_phase = r_cfg_phase;
  assign bus.cfg_amp   = r_cfg_amp;
  assign bus.cfg_wave  = r_cfg_wave;
  assign bus.dds_en    = r_dds_en;
  assign bus.led_en    = r_led_en;
  assign bus.err       = r_err;
  assign bus.drop_cnt  = r_drop_cnt;

endmodule

// File: doc/dds_cmd_ctrl.md
Name: dds_cmd_ctrl

Overview:
Command sequencer between the multi-byte UART packet receiver and the DDS core. Decodes each received packet (cmd byte, two 16-bit words, one trailing byte) into shadow configuration registers. On a commit command it transfers the shadow set to the DDS through a valid/ready handshake. Also drives the LED-mode enable and an optional status byte back to the UART transmitter.

Parameters:
FTW_W, 32, DDS frequency tuning word width (= 2x16-bit packet words)
PHW_W, 16, phase offset width
AMP_W, 12, amplitude width (low bits of dataC)
TO_CYC, 65535, cycles to wait for cfg_ready before a timeout error (16-bit counter)

Ports:
sys_clk  in  1  system clock (50 MHz domain)
sys_rst  in  1  synchronous reset, active-high
recv_done  in  1  one-cycle pulse: packet fields valid
dataA  in  8  command byte
dataB  in  16  parameter word high
dataC  in  16  parameter word low
dataD  in  8  auxiliary byte
cfg_valid  out  1  configuration transfer request to DDS
cfg_ready  in  1  DDS accepts configuration
cfg_ftw  out  FTW_W  active frequency tuning word
cfg_phase  out  PHW_W  active phase offset
cfg_amp  out  AMP_W  active amplitude
cfg_wave  out  2  waveform select (0 sine, 1 square, 2 triangle, 3 saw)
dds_en  out  1  DDS output enable
led_en  out  1  LED breathing enable
busy  out  1  high when FSM not in IDLE
err  out  1  sticky error flag; cleared by CLR command or reset
drop_cnt  out  8  saturating count of packets dropped while busy

Behaviour:
- Reset (sync, sys_rst=1 sampled at sys_clk edge): all outputs 0; shadow registers 0; FSM IDLE. Reset mid-transfer aborts immediately; cfg_valid is 0 the next cycle.
- FSM states: IDLE, DECODE, XFER, REPLY (REPLY exists only with feature).
- IDLE: recv_done=1 -> latch dataA..dataD, go DECODE next cycle.
- DECODE (1 cycle), by dataA:
  0x01 shadow_ftw <= {dataB,dataC}
  0x02 shadow_phase <= dataB
  0x03 shadow_amp <= dataC[AMP_W-1:0]
  0x04 shadow_wave <= dataD[1:0]
  0x08 led_en <= dataD[0] (immediate, no commit)
  0x10 commit: dds_en shadow <= dataD[0]; go XFER
  0x7F CLR: err <= 0, drop_cnt <= 0
  Any other code: err <= 1, no register change.
  All codes except 0x10 return to IDLE (or REPLY).
- XFER: cfg_valid=1 while cfg_* outputs hold the shadow values; cfg_* and dds_en update from shadow on the cycle entering XFER and stay stable while cfg_valid=1. Transfer completes on the cycle with cfg_valid&cfg_ready=1: cfg_valid drops next cycle and the FSM goes to IDLE/REPLY. Timeout counter counts cycles in XFER; at TO_CYC without ready: err<=1, cfg_valid<=0, leave XFER (cfg_* retain new values, dds_en forced 0).
- Latency: recv_done to shadow update = 2 cycles; recv_done to cfg_valid rising = 2 cycles; cfg_ready=1 already high -> handshake completes on first XFER cycle.
- recv_done while not IDLE: packet dropped, drop_cnt+1, saturating at 255; recv_done in the same cycle the FSM returns to IDLE is also dropped.
- busy = (state != IDLE), combinational from the state register.

Optional Feature:
DDS_CMD_REPLY_EN: when defined, after DECODE or XFER the FSM enters REPLY and asserts tx_req (out, 1) with tx_data (out, 8):
- 0xA5 = ok; 0xE1 = bad command; 0xE2 = timeout.
- tx_req is held until tx_busy (in, 1) has been seen high then low; then IDLE.
When undefined: no REPLY state, no tx_* ports, tx logic absent.

Decomposition:
- Package dds_cmd_pkg: command code constants (CMD_FTW, CMD_PHASE, CMD_AMP, CMD_WAVE, CMD_LED, CMD_COMMIT, CMD_CLR), reply codes, state enumeration, waveform encoding.
- One sub-module: dds_cmd_timeout (load/count/expire counter, parameter TO_CYC), reused for XFER and REPLY waits.

Test Plan:
- Pkt 0x01,B=0x1234,C=0x5678 then 0x10,D=0x01 with cfg_ready tied 1 -> cfg_valid one cycle, cfg_ftw=0x12345678, dds_en=1, err=0.
- Commit with cfg_ready held 0 for 10 cycles then 1 -> cfg_valid high 11 cycles, cfg_* stable throughout, single transfer.
- cfg_ready stuck 0 with TO_CYC=16 -> cfg_valid drops after 16 cycles, err=1, dds_en=0; then CMD 0x7F -> err=0.
- Pkt dataA=0x55 -> err=1, all cfg_* unchanged; 3 recv_done pulses during XFER -> drop_cnt=3; 300 pulses -> drop_cnt=255.
- CMD 0x08 with D=0x01 -> led_en=1 two cycles after recv_done, cfg_valid stays 0; sys_rst asserted mid-XFER -> next cycle all outputs 0, state IDLE.
- DDS_CMD_REPLY_EN defined: good commit -> tx_data=0xA5; bad code -> 0xE1; tx_req held until tx_busy has gone high and then low.
